// File: rtl/chan_mux_scan_pkg.sv
// Shared types and helpers for the scanning channel multiplexer.
package chan_mux_scan_pkg;

  typedef enum logic {
    S_MAN  = 1'b0,
    S_SCAN = 1'b1
  } state_e;

  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(v)) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/chan_mux_scan_rr_next_en.sv
// Circular search for the first set mask bit at or after start (or strictly after it).
module rr_next_en #(
  parameter int unsigned CHANNELS = 4,
  parameter int unsigned SELW     = 2
) (
  input  logic [CHANNELS-1:0] mask,
  input  logic [SELW-1:0]     start,
  input  logic                incl_start,
  output logic [SELW-1:0]     idx,
  output logic                found
);

  logic [SELW-1:0] cand;

  // Without incl_start the last candidate wraps back onto start itself.
  always_comb begin
    idx   = '0;
    found = 1'b0;
    cand  = '0;
    for (int unsigned off = 0; off < CHANNELS; off++) begin
      cand = SELW'((32'(start) + off + 32'(!incl_start)) % CHANNELS);
      if (!found && mask[cand]) begin
        found = 1'b1;
        idx   = cand;
      end
    end
  end

endmodule

// File: rtl/chan_mux_scan.sv
// Registered N-channel mux with manual select and round-robin auto-scan over enabled channels.
module chan_mux_scan
  import chan_mux_scan_pkg::*;
#(
  parameter  int unsigned WIDTH    = 8,
  parameter  int unsigned CHANNELS = 4,
  parameter  int unsigned DWELL    = 4,
  localparam int unsigned SELW     = (clog2(CHANNELS) < 1) ? 1 : clog2(CHANNELS)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      mode,
  input  logic [SELW-1:0]           sel_in,
  input  logic [CHANNELS-1:0]       ch_en,
  input  logic [CHANNELS*WIDTH-1:0] din,
  output logic [WIDTH-1:0]          dout,
  output logic [SELW-1:0]           dout_ch,
  output logic                      dout_valid
);

  localparam int unsigned CNTW = clog2(DWELL) + 1;

  state_e            state_q, state_d;
  logic [SELW-1:0]   ptr_q, ptr_d;
  logic [CNTW-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]  dout_q, dout_d;
  logic [SELW-1:0]   dout_ch_q, dout_ch_d;
  logic              valid_q, valid_d;

  logic [WIDTH-1:0]  ch_data [CHANNELS];
  logic              sel_ok;
  logic [SELW-1:0]   entry_idx, adv_idx;
  logic              entry_found, adv_found;

  for (genvar k = 0; k < CHANNELS; k++) begin : g_unpack
    assign ch_data[k] = din[k*WIDTH +: WIDTH];
  end

  assign sel_ok = (32'(sel_in) < CHANNELS);

  rr_next_en #(.CHANNELS(CHANNELS), .SELW(SELW)) u_entry (
    .mask       (ch_en),
    .start      ('0),
    .incl_start (1'b1),
    .idx        (entry_idx),
    .found      (entry_found)
  );

  rr_next_en #(.CHANNELS(CHANNELS), .SELW(SELW)) u_adv (
    .mask       (ch_en),
    .start      (ptr_q),
    .incl_start (1'b0),
    .idx        (adv_idx),
    .found      (adv_found)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_MAN;
      ptr_q     <= '0;
      cnt_q     <= '0;
      dout_q    <= '0;
      dout_ch_q <= '0;
      valid_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      cnt_q     <= cnt_d;
      dout_q    <= dout_d;
      dout_ch_q <= dout_ch_d;
      valid_q   <= valid_d;
    end
  end

  // On mode-change edges the outputs still follow the rules of the state being left.
  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    cnt_d     = cnt_q;
    dout_d    = dout_q;
    dout_ch_d = dout_ch_q;
    valid_d   = 1'b0;
    unique case (state_q)
      S_MAN: begin
        if (sel_ok) begin
          dout_d    = ch_data[sel_in];
          dout_ch_d = sel_in;
          valid_d   = ch_en[sel_in];
        end
        if (mode) begin
          state_d = S_SCAN;
          ptr_d   = entry_found ? entry_idx : '0;
          cnt_d   = '0;
        end
      end
      S_SCAN: begin
        if (ch_en != '0) begin
          dout_d    = ch_data[ptr_q];
          dout_ch_d = ptr_q;
          valid_d   = ch_en[ptr_q];
          if (!ch_en[ptr_q] || (cnt_q == CNTW'(DWELL - 1))) begin
            if (adv_found) ptr_d = adv_idx;
            cnt_d = '0;
          end else begin
            cnt_d = cnt_q + CNTW'(1);
          end
        end
        if (!mode) begin
          state_d = S_MAN;
          ptr_d   = '0;
          cnt_d   = '0;
        end
      end
    endcase
  end

  assign dout       = dout_q;
  assign dout_ch    = dout_ch_q;
  assign dout_valid = valid_q;

endmodule

// File: tb/tb_chan_mux_scan.sv
// Self-checking bench: 4-channel and 3-channel builds against a behavioural model.
module tb_chan_mux_scan;

  localparam int DW = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        mode;
  logic [1:0]  sel;
  logic [3:0]  en;
  logic [31:0] din;

  logic [7:0]  dout_a, dout_b;
  logic [1:0]  ch_a, ch_b;
  logic        val_a, val_b;

  int n_checks = 0;
  int n_fail   = 0;

  int m_scan [2];
  int m_ptr  [2];
  int m_cnt  [2];
  int m_dout [2];
  int m_ch   [2];
  int m_val  [2];

  always #5 clk = ~clk;

  chan_mux_scan #(.WIDTH(8), .CHANNELS(4), .DWELL(4)) u_dut_a (
    .clk(clk), .rst(rst), .mode(mode), .sel_in(sel), .ch_en(en), .din(din),
    .dout(dout_a), .dout_ch(ch_a), .dout_valid(val_a)
  );

  chan_mux_scan #(.WIDTH(8), .CHANNELS(3), .DWELL(4)) u_dut_b (
    .clk(clk), .rst(rst), .mode(mode), .sel_in(sel), .ch_en(en[2:0]), .din(din[23:0]),
    .dout(dout_b), .dout_ch(ch_b), .dout_valid(val_b)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic int ch_val(input logic [31:0] dv, input int k);
    return int'((dv >> (k * 8)) & 32'hFF);
  endfunction

  // First enabled channel in circular order starting at start (or just after it).
  function automatic int next_en(input int n, input logic [3:0] m, input int start, input bit incl);
    int lo;
    lo = incl ? 0 : 1;
    for (int off = lo; off < lo + n; off++) begin
      if (m[(start + off) % n]) return (start + off) % n;
    end
    return -1;
  endfunction

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      m_scan[d] = 0; m_ptr[d] = 0; m_cnt[d] = 0;
      m_dout[d] = 0; m_ch[d] = 0; m_val[d] = 0;
    end
  endtask

  task automatic step(input int d, input int n, input bit md, input int s,
                      input logic [3:0] e, input logic [31:0] dv);
    logic [3:0] em;
    em = e & 4'((1 << n) - 1);
    if (m_scan[d] == 0) begin
      if (s < n) begin
        m_dout[d] = ch_val(dv, s);
        m_ch[d]   = s;
        m_val[d]  = int'(em[s]);
      end else begin
        m_val[d] = 0;
      end
      if (md) begin
        m_scan[d] = 1;
        m_ptr[d]  = (em == 4'd0) ? 0 : next_en(n, em, 0, 1'b1);
        m_cnt[d]  = 0;
      end
    end else begin
      if (em == 4'd0) begin
        m_val[d] = 0;
      end else begin
        m_dout[d] = ch_val(dv, m_ptr[d]);
        m_ch[d]   = m_ptr[d];
        m_val[d]  = int'(em[m_ptr[d]]);
        if (em[m_ptr[d]] == 1'b0 || m_cnt[d] == DW - 1) begin
          m_ptr[d] = next_en(n, em, m_ptr[d], 1'b0);
          m_cnt[d] = 0;
        end else begin
          m_cnt[d] = m_cnt[d] + 1;
        end
      end
      if (!md) begin
        m_scan[d] = 0; m_ptr[d] = 0; m_cnt[d] = 0;
      end
    end
  endtask

  // One clock: model sees the same inputs the DUTs sample, outputs checked 1 unit later.
  task automatic tick(input string tag);
    @(posedge clk);
    step(0, 4, mode, int'(sel), en, din);
    step(1, 3, mode, int'(sel), {1'b0, en[2:0]}, {8'h00, din[23:0]});
    #1;
    check({tag, ".a.dout"},  32'(dout_a), 32'(m_dout[0]));
    check({tag, ".a.ch"},    32'(ch_a),   32'(m_ch[0]));
    check({tag, ".a.valid"}, 32'(val_a),  32'(m_val[0]));
    check({tag, ".b.dout"},  32'(dout_b), 32'(m_dout[1]));
    check({tag, ".b.ch"},    32'(ch_b),   32'(m_ch[1]));
    check({tag, ".b.valid"}, 32'(val_b),  32'(m_val[1]));
    @(negedge clk);
  endtask

  task automatic pulse_reset();
    #1 rst = 1'b1;
    #1;
    check("rst.a.dout", 32'(dout_a), 32'h0);
    check("rst.a.ch",   32'(ch_a),   32'h0);
    check("rst.a.val",  32'(val_a),  32'h0);
    check("rst.b.dout", 32'(dout_b), 32'h0);
    check("rst.b.val",  32'(val_b),  32'h0);
    model_reset();
    #1 rst = 1'b0;
  endtask

  initial begin
    rst  = 1'b1;
    mode = 1'b0;
    sel  = 2'd0;
    en   = 4'hF;
    din  = 32'hDDCC_BBAA;
    model_reset();
    @(negedge clk);
    pulse_reset();

    // Manual selection, one edge of latency.
    sel = 2'd0; tick("t2.s0"); check("t2.aa", 32'(dout_a), 32'hAA);
    sel = 2'd2; tick("t2.s2"); check("t2.cc", 32'(dout_a), 32'hCC);
    sel = 2'd3; tick("t2.s3"); check("t2.dd", 32'(dout_a), 32'hDD);
    check("t6.b.hold", 32'(dout_b), 32'hCC);
    check("t6.b.inval", 32'(val_b), 32'h0);
    en = 4'hB; sel = 2'd2; tick("t2.dis");
    check("t2.dis.dout", 32'(dout_a), 32'hCC);
    check("t2.dis.val",  32'(val_a),  32'h0);

    // Full scan with wrap.
    en = 4'hF; sel = 2'd0; tick("t3.pre");
    mode = 1'b1; tick("t3.entry");
    for (int i = 0; i < 20; i++) begin
      tick("t3");
      check("t3.seq", 32'(dout_a), 32'hAA + 32'h11 * 32'((i / 4) % 4));
      check("t3.ch",  32'(ch_a),   32'((i / 4) % 4));
    end

    // Scan over channels 1 and 3, then drop channel 3 mid-dwell.
    mode = 1'b0; en = 4'b1010; tick("t4.exit");
    mode = 1'b1; tick("t4.entry");
    for (int i = 0; i < 12; i++) begin
      tick("t4");
      check("t4.seq", 32'(dout_a), ((i / 4) % 2 == 1) ? 32'hDD : 32'hBB);
    end
    tick("t4.dd1");
    en = 4'b0010; tick("t4.drop");
    check("t4.drop.val", 32'(val_a), 32'h0);
    for (int i = 0; i < 8; i++) begin
      tick("t4.bb");
      check("t4.bb.dout", 32'(dout_a), 32'hBB);
      check("t4.bb.val",  32'(val_a),  32'h1);
    end

    // All channels disabled, then only channel 2.
    en = 4'b0000;
    for (int i = 0; i < 3; i++) begin
      tick("t5.off");
      check("t5.off.val",  32'(val_a),  32'h0);
      check("t5.off.hold", 32'(dout_a), 32'hBB);
    end
    en = 4'b0100; tick("t5.on1"); tick("t5.on2");
    check("t5.cc", 32'(dout_a), 32'hCC);
    check("t5.cc.val", 32'(val_a), 32'h1);
    for (int i = 0; i < 6; i++) begin
      tick("t5.dwell");
      check("t5.dwell.dout", 32'(dout_a), 32'hCC);
    end

    // Asynchronous reset in the middle of a scan, then manual select.
    pulse_reset();
    mode = 1'b0; sel = 2'd1; en = 4'hF; tick("t1.man");
    check("t1.dout", 32'(dout_a), 32'hBB);
    check("t1.ch",   32'(ch_a),   32'h1);
    check("t1.val",  32'(val_a),  32'h1);

    // Repeated scan entries restart at channel 0.
    for (int r = 0; r < 2; r++) begin
      mode = 1'b1; sel = 2'd2; tick("t6.entry");
      tick("t6.first");
      check("t6.a.ch0", 32'(ch_a), 32'h0);
      check("t6.b.ch0", 32'(ch_b), 32'h0);
      mode = 1'b0; tick("t6.exit");
    end

    // Randomised traffic.
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 11) == 0) mode = ~mode;
      sel = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 5) == 0) en = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 9) == 0) en = 4'd0;
      if ($urandom_range(0, 3) == 0) din = $urandom;
      if ($urandom_range(0, 149) == 0) pulse_reset();
      tick("rnd");
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
